// File: rtl/scm_pkg.sv
// Shared definitions for the scm statistics run sequencer: run states, register map,
// STATUS layout and small arithmetic helpers.
package scm_pkg;

  localparam logic [3:0] SCM_LMID = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_WARMUP = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } run_state_e;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_RUN_LEN = 2'd1;
  localparam logic [1:0] REG_WARMUP  = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_ABORT_BIT = 1;

  localparam int unsigned ST_ERR_BIT     = 0;
  localparam int unsigned ST_BUSY_BIT    = 1;
  localparam int unsigned ST_DONE_BIT    = 2;
  localparam int unsigned ST_STATE_LSB   = 3;
  localparam int unsigned ST_TIMEOUT_BIT = 31;

  typedef struct packed {
    logic       timeout;
    logic [2:0] state;
    logic       done;
    logic       busy;
    logic       err;
  } run_status_t;

  function automatic logic [31:0] pack_status(input run_status_t s);
    logic [31:0] r;
    r                     = '0;
    r[ST_TIMEOUT_BIT]     = s.timeout;
    r[ST_STATE_LSB +: 3]  = s.state;
    r[ST_DONE_BIT]        = s.done;
    r[ST_BUSY_BIT]        = s.busy;
    r[ST_ERR_BIT]         = s.err;
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/scm_run_regfile.sv
// Register decode and readback for the run sequencer: CTRL strobes, RUN_LEN/WARMUP
// storage and STATUS readback with a one-cycle registered read response.
module scm_run_regfile
  import scm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h7000_0010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        cfg_rd_valid,
  input  run_status_t status,
  output logic        start_req,
  output logic        abort_req,
  output logic [31:0] run_len,
  output logic [31:0] warmup
);

  logic [31:0] offset;
  logic        hit;
  logic [1:0]  sel;
  logic [31:0] run_len_q, run_len_d;
  logic [31:0] warmup_q, warmup_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_valid_q, rd_valid_d;

  always_comb begin
    // Subtract-and-test keeps the window correct for any BASE_ADDR alignment.
    offset    = cfg_addr - BASE_ADDR;
    hit       = (offset[31:2] == '0);
    sel       = offset[1:0];
    start_req = cfg_wr && hit && (sel == REG_CTRL) &&
                cfg_wdata[CTRL_START_BIT] && !cfg_wdata[CTRL_ABORT_BIT];
    abort_req = cfg_wr && hit && (sel == REG_CTRL) && cfg_wdata[CTRL_ABORT_BIT];

    run_len_d = run_len_q;
    warmup_d  = warmup_q;
    if (cfg_wr && hit && (sel == REG_RUN_LEN)) run_len_d = cfg_wdata;
    if (cfg_wr && hit && (sel == REG_WARMUP))  warmup_d  = cfg_wdata;

    rd_valid_d = cfg_rd;
    rdata_d    = '0;
    if (cfg_rd && hit) begin
      case (sel)
        REG_RUN_LEN: rdata_d = run_len_q;
        REG_WARMUP:  rdata_d = warmup_q;
        REG_STATUS:  rdata_d = pack_status(status);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_len_q  <= '0;
      warmup_q   <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      run_len_q  <= run_len_d;
      warmup_q   <= warmup_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign run_len      = run_len_q;
  assign warmup       = warmup_q;
  assign cfg_rdata    = rdata_q;
  assign cfg_rd_valid = rd_valid_q;

endmodule

// File: rtl/scm_run_sched.sv
// Sequences one scm statistics run: CLEAR -> WARMUP -> RUN -> DRAIN -> DONE,
// driving counter clear, generator enable and the sent_start/sent_end window.
module scm_run_sched
  import scm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h7000_0010,
  parameter int unsigned CLR_CYCLES    = 4,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        cfg_rd_valid,
  input  logic        scm_idle,
  output logic        stat_reset,
  output logic        gen_en,
  output logic        sent_start,
  output logic        sent_end,
  output logic        run_busy
);

  run_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] run_len_lat_q, run_len_lat_d;
  logic [31:0] warmup_lat_q, warmup_lat_d;
  logic        err_q, err_d;
  logic        timeout_q, timeout_d;
  logic        stat_reset_q, stat_reset_d;
  logic        gen_en_q, gen_en_d;
  logic        sent_start_q, sent_start_d;
  logic        sent_end_q, sent_end_d;
  logic        run_busy_q, run_busy_d;
  logic        start_req, abort_req, drain_exit;
  logic [31:0] run_len, warmup;
  run_status_t status;

  always_comb begin
    status.timeout = timeout_q;
    status.state   = state_q;
    status.done    = (state_q == ST_DONE);
    status.busy    = run_busy_q;
    status.err     = err_q;
  end

  scm_run_regfile #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regfile (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_wr       (cfg_wr),
    .cfg_rd       (cfg_rd),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .cfg_rd_valid (cfg_rd_valid),
    .status       (status),
    .start_req    (start_req),
    .abort_req    (abort_req),
    .run_len      (run_len),
    .warmup       (warmup)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = sat_inc(cnt_q);
    run_len_lat_d = run_len_lat_q;
    warmup_lat_d  = warmup_lat_q;
    err_d         = err_q;
    timeout_d     = timeout_q;
    drain_exit    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_req) begin
          if (run_len != '0) begin
            state_d       = ST_CLEAR;
            cnt_d         = '0;
            run_len_lat_d = run_len;
            warmup_lat_d  = warmup;
            err_d         = 1'b0;
            timeout_d     = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (abort_req) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else if (cnt_q == 32'(CLR_CYCLES - 1)) begin
          state_d = ST_WARMUP;
          cnt_d   = '0;
        end
      end
      ST_WARMUP: begin
        // A zero warm-up still spends one cycle here, same as a warm-up of one.
        if (abort_req) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else if ((warmup_lat_q == '0) || (cnt_q == warmup_lat_q - 32'd1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (abort_req || (cnt_q == run_len_lat_q - 32'd1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (scm_idle) begin
          state_d    = ST_DONE;
          drain_exit = 1'b1;
        end else if (cnt_q == 32'(DRAIN_TIMEOUT - 1)) begin
          state_d    = ST_DONE;
          drain_exit = 1'b1;
          timeout_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_req && (state_q inside {ST_CLEAR, ST_WARMUP, ST_RUN, ST_DRAIN})) err_d = 1'b1;

    stat_reset_d = (state_d == ST_CLEAR);
    gen_en_d     = (state_d == ST_WARMUP) || (state_d == ST_RUN);
    sent_start_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    sent_end_d   = drain_exit;
    run_busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      run_len_lat_q <= '0;
      warmup_lat_q  <= '0;
      err_q         <= 1'b0;
      timeout_q     <= 1'b0;
      stat_reset_q  <= 1'b0;
      gen_en_q      <= 1'b0;
      sent_start_q  <= 1'b0;
      sent_end_q    <= 1'b0;
      run_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      run_len_lat_q <= run_len_lat_d;
      warmup_lat_q  <= warmup_lat_d;
      err_q         <= err_d;
      timeout_q     <= timeout_d;
      stat_reset_q  <= stat_reset_d;
      gen_en_q      <= gen_en_d;
      sent_start_q  <= sent_start_d;
      sent_end_q    <= sent_end_d;
      run_busy_q    <= run_busy_d;
    end
  end

  assign stat_reset = stat_reset_q;
  assign gen_en     = gen_en_q;
  assign sent_start = sent_start_q;
  assign sent_end   = sent_end_q;
  assign run_busy   = run_busy_q;

endmodule

// File: tb/tb_scm_run_sched.sv
// Bench for scm_run_sched: timeline-based reference model checked every cycle,
// plus literal expectations on phase lengths and STATUS values.
module tb_scm_run_sched;

  localparam logic [31:0] BASE = 32'h7000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic        cfg_rd = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        scm_idle = 1'b0;
  logic [31:0] cfg_rdata;
  logic        cfg_rd_valid;
  logic        stat_reset, gen_en, sent_start, sent_end, run_busy;

  scm_run_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_wr       (cfg_wr),
    .cfg_rd       (cfg_rd),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .cfg_rd_valid (cfg_rd_valid),
    .scm_idle     (scm_idle),
    .stat_reset   (stat_reset),
    .gen_en       (gen_en),
    .sent_start   (sent_start),
    .sent_end     (sent_end),
    .run_busy     (run_busy)
  );

  always #5 clk = ~clk;

  // Reference model: a run is a timeline of absolute edge numbers fixed at start.
  // Phase codes: 0 idle, 1 clear, 2 warmup, 3 run, 4 drain, 5 done.
  longint      cyc = 0;
  int          m_phase = 0;
  bit          m_active = 0;
  longint      t0 = 0, wq = 0, rl = 0, d0 = 0;
  logic [31:0] m_run_len = '0, m_warmup = '0;
  bit          m_err = 0, m_tflag = 0;
  bit          e_stat = 0, e_gen = 0, e_ss = 0, e_end = 0, e_busy = 0, e_rdv = 0;
  logic [31:0] e_rdata = '0;

  function automatic int phase_at(input longint e);
    if (e >= d0)          return 4;
    if (e < t0 + 4)       return 1;
    if (e < t0 + 4 + wq)  return 2;
    return 3;
  endfunction

  function automatic logic [31:0] read_model(input logic [31:0] a, input int ph);
    logic [31:0] v;
    logic [2:0]  s;
    v = '0;
    s = 3'(ph);
    if (a == BASE + 32'd1) v = m_run_len;
    else if (a == BASE + 32'd2) v = m_warmup;
    else if (a == BASE + 32'd3) begin
      v[31]  = m_tflag;
      v[5:3] = s;
      v[2]   = (ph == 5);
      v[1]   = (ph >= 1 && ph <= 4);
      v[0]   = m_err;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    int  prev;
    bit  start, abort;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_phase = 0; m_active = 0; m_run_len = '0; m_warmup = '0;
      m_err = 0; m_tflag = 0;
      e_stat = 0; e_gen = 0; e_ss = 0; e_end = 0; e_busy = 0; e_rdv = 0; e_rdata = '0;
    end else begin
      prev    = m_phase;
      e_rdv   = cfg_rd;
      e_rdata = cfg_rd ? read_model(cfg_addr, prev) : '0;
      start   = cfg_wr && (cfg_addr == BASE) && cfg_wdata[0] && !cfg_wdata[1];
      abort   = cfg_wr && (cfg_addr == BASE) && cfg_wdata[1];
      e_end   = 0;
      if (prev == 0 || prev == 5) begin
        if (start) begin
          if (m_run_len != 0) begin
            t0 = cyc;
            wq = (m_warmup == 0) ? 1 : longint'(m_warmup);
            rl = longint'(m_run_len);
            d0 = t0 + 4 + wq + rl;
            m_active = 1; m_err = 0; m_tflag = 0;
          end else m_err = 1;
        end
      end else begin
        if (start) m_err = 1;
        if (abort && prev != 4) d0 = cyc;
        if (prev == 4) begin
          if (scm_idle) begin
            m_active = 0; e_end = 1;
          end else if (cyc - d0 == 1024) begin
            m_active = 0; e_end = 1; m_tflag = 1;
          end
        end
      end
      if (cfg_wr && cfg_addr == BASE + 32'd1) m_run_len = cfg_wdata;
      if (cfg_wr && cfg_addr == BASE + 32'd2) m_warmup  = cfg_wdata;
      m_phase = m_active ? phase_at(cyc) : (e_end ? 5 : prev);
      e_stat  = (m_phase == 1);
      e_gen   = (m_phase == 2 || m_phase == 3);
      e_ss    = (m_phase == 3 || m_phase == 4);
      e_busy  = (m_phase >= 1 && m_phase <= 4);
    end
  end

  int n_total = 0, n_pass = 0;
  int clr_cnt = 0, gen_cnt = 0, run_cnt = 0, drain_cnt = 0, end_cnt = 0;
  int b_clr, b_gen, b_run, b_drain, b_end;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("outputs{stat_reset,gen_en,sent_start,sent_end,run_busy,rd_valid}",
            {26'd0, stat_reset, gen_en, sent_start, sent_end, run_busy, cfg_rd_valid},
            {26'd0, e_stat, e_gen, e_ss, e_end, e_busy, e_rdv});
        if (e_rdv) chk("rdata", cfg_rdata, e_rdata);
        if (stat_reset)             clr_cnt++;
        if (gen_en)                 gen_cnt++;
        if (gen_en && sent_start)   run_cnt++;
        if (sent_start && !gen_en)  drain_cnt++;
        if (sent_end)               end_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    cfg_rd = 1'b1; cfg_addr = a;
    tick();
    cfg_rd = 1'b0;
    chk({name, " rd_valid"}, {31'd0, cfg_rd_valid}, 32'd1);
    chk(name, cfg_rdata, exp);
  endtask

  task automatic snap();
    b_clr = clr_cnt; b_gen = gen_cnt; b_run = run_cnt; b_drain = drain_cnt; b_end = end_cnt;
  endtask

  task automatic wait_end(input string name, input int budget);
    for (int i = 0; i < budget && end_cnt == b_end; i++) tick();
    tick();
    chk({name, " sent_end pulses"}, 32'(end_cnt - b_end), 32'd1);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    rd_chk("status after reset", BASE + 32'd3, 32'h0);

    // Nominal run: RUN_LEN=100, WARMUP=10
    wr(BASE + 32'd1, 32'd100);
    wr(BASE + 32'd2, 32'd10);
    snap();
    wr(BASE, 32'h1);
    repeat (120) tick();
    scm_idle = 1'b1;
    wait_end("nominal", 200);
    chk("nominal stat_reset cycles", 32'(clr_cnt - b_clr), 32'd4);
    chk("nominal gen_en cycles", 32'(gen_cnt - b_gen), 32'd110);
    chk("nominal counting cycles", 32'(run_cnt - b_run), 32'd100);
    rd_chk("nominal status", BASE + 32'd3, 32'h0000_002C);
    rd_chk("run_len readback", BASE + 32'd1, 32'd100);

    // Zero-length start from IDLE
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    snap();
    wr(BASE, 32'h1);
    repeat (5) tick();
    rd_chk("zero-len status", BASE + 32'd3, 32'h0000_0001);
    chk("zero-len gen_en cycles", 32'(gen_cnt - b_gen), 32'd0);

    // Abort during RUN (start+abort written together: abort wins)
    scm_idle = 1'b0;
    wr(BASE + 32'd1, 32'd1000);
    wr(BASE + 32'd2, 32'd0);
    snap();
    wr(BASE, 32'h1);
    for (int i = 0; i < 100 && (run_cnt - b_run) < 19; i++) tick();
    wr(BASE, 32'h3);
    repeat (5) tick();
    scm_idle = 1'b1;
    wait_end("abort", 50);
    chk("abort counting cycles", 32'(run_cnt - b_run), 32'd20);
    chk("abort drain cycles", 32'(drain_cnt - b_drain), 32'd6);
    rd_chk("abort status", BASE + 32'd3, 32'h0000_002C);

    // Drain timeout, with a rejected start while busy
    scm_idle = 1'b0;
    wr(BASE + 32'd1, 32'd5);
    wr(BASE + 32'd2, 32'd2);
    snap();
    wr(BASE, 32'h1);
    repeat (50) tick();
    wr(BASE, 32'h1);
    wait_end("timeout", 2000);
    chk("timeout drain cycles", 32'(drain_cnt - b_drain), 32'd1024);
    rd_chk("timeout status", BASE + 32'd3, 32'h8000_002D);

    // Reset mid-run, then a fresh run
    scm_idle = 1'b1;
    wr(BASE + 32'd1, 32'd1000);
    wr(BASE, 32'h1);
    repeat (30) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    rd_chk("run_len after reset", BASE + 32'd1, 32'h0);
    rd_chk("status after mid-run reset", BASE + 32'd3, 32'h0);
    wr(BASE + 32'd1, 32'd100);
    wr(BASE + 32'd2, 32'd10);
    snap();
    wr(BASE, 32'h1);
    wait_end("fresh", 400);
    chk("fresh stat_reset cycles", 32'(clr_cnt - b_clr), 32'd4);
    chk("fresh gen_en cycles", 32'(gen_cnt - b_gen), 32'd110);
    chk("fresh drain cycles", 32'(drain_cnt - b_drain), 32'd1);

    // Unmapped reads, CTRL readback, and simultaneous read/write
    rd_chk("unmapped 0x70000020", 32'h7000_0020, 32'h0);
    rd_chk("unmapped below base", 32'h7000_000F, 32'h0);
    rd_chk("ctrl readback", BASE, 32'h0);
    cfg_wr = 1'b1; cfg_rd = 1'b1; cfg_addr = BASE + 32'd1; cfg_wdata = 32'd7;
    tick();
    cfg_wr = 1'b0; cfg_rd = 1'b0;
    chk("rw same cycle old value", cfg_rdata, 32'd100);
    rd_chk("rw same cycle new value", BASE + 32'd1, 32'd7);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
